ctrl_unit: RTL and testbench
============================

CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 Parameter RETIRE_W, 16, width of retired-instruction counter.
REQ-002 Parameter HALT_OP, 6'b111111, opcode that stops execution.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Opcode  input  6  opcode of current instruction from datapath.
REQ-006 zero  input  1  registered zero flag from datapath.
REQ-007 s_inc  output  1  PC mux select: 1 = PC+1, 0 = jump address.
REQ-008 s_inm  output  1  write-data select: 1 = immediate, 0 = ALU result.
REQ-009 we  output  1  register-file write enable.
REQ-010 wez  output  1  zero-flag write enable.
REQ-011 ALUOp  output  3  ALU operation select.
REQ-012 pc_en  output  1  PC register load enable; datapath PC SHALL hold when 0.
REQ-013 halted  output  1  high while in HALT.
REQ-014 retired  output  RETIRE_W  count of executed instructions.

Function
REQ-015 Decode SHALL be: 0aaa00 = ALU (ALUOp=aaa, we=1, wez=1, s_inm=0, s_inc=1); 0xxx01 = LI (we=1, s_inm=1, wez=0, ALUOp=000, s_inc=1); 100000 = J (s_inc=0); 100001 = JZ (s_inc=~zero); 100010 = JNZ (s_inc=zero); HALT_OP = halt; all others = NOP (s_inc=1, we=wez=0).
REQ-016 States SHALL be BOOT, RUN, HALT (plus STEP_WAIT, STEP_EXEC, STEP_DONE under REQ-027).
REQ-017 BOOT SHALL last exactly one cycle after reset release: pc_en=0, we=wez=0, then -> RUN.
REQ-018 In RUN, outputs SHALL follow REQ-015 combinationally from Opcode/zero in the same cycle (zero-latency decode); pc_en=1.
REQ-019 HALT_OP decoded in RUN SHALL force pc_en=0, we=wez=0 that cycle and transition to HALT next edge.
REQ-020 In HALT: pc_en=0, we=wez=0, s_inc=1, s_inm=0, ALUOp=000, halted=1; exit only by reset.
REQ-021 retired SHALL increment by 1 on each edge ending a RUN/STEP_EXEC cycle whose opcode is not HALT_OP; saturates at all-ones (no wrap).
REQ-022 Conditional jumps SHALL sample zero in the execute cycle; a wez write in that same cycle does not affect it.
REQ-023 Outputs not driven by decode in BOOT/HALT/STEP_WAIT/STEP_DONE SHALL be s_inc=1, s_inm=0, ALUOp=000.

Reset
REQ-024 reset=0 SHALL immediately force state=BOOT, retired=0, halted=0, pc_en=0, we=wez=0, s_inc=1, s_inm=0, ALUOp=000 (and step_ack=0), independent of clk.
REQ-025 Reset asserted mid-instruction or in HALT SHALL abort without any further we/wez pulse.
REQ-026 Reset release SHALL take effect at the first rising edge with reset=1.

Configuration
REQ-027 Macro CTRL_UNIT_STEP_EN SHALL add ports step_mode (in 1), step_req (in 1), step_ack (out 1) and states STEP_WAIT/STEP_EXEC/STEP_DONE.
REQ-028 With macro: BOOT or RUN with step_mode=1 -> STEP_WAIT (pc_en=0, writes 0); step_req=1 -> STEP_EXEC (one instruction executed as in RUN, step_ack=1) -> STEP_DONE (pc_en=0) until step_req=0 -> STEP_WAIT, or RUN if step_mode=0.
REQ-029 With macro: HALT_OP in STEP_EXEC SHALL go to HALT; step_ack still pulses.
REQ-030 Without macro: ports and step states absent; behaviour identical to step_mode=0.

Structure
REQ-031 Shared package SHALL hold opcode constants (OP_J, OP_JZ, OP_JNZ, OP_HALT), ALU/LI class patterns, state encoding typedef.
REQ-032 One sub-module ctrl_decode (pure combinational opcode/zero -> control word); FSM and counter remain in ctrl_unit.

Verification
REQ-033 Reset release, Opcode=000000 -> cycle 1 pc_en=0 we=0; cycle 2 we=1 wez=1 ALUOp=000 pc_en=1.
REQ-034 RUN, Opcode=100001, zero=1 -> s_inc=0; zero=0 -> s_inc=1; Opcode=100010 inverse.
REQ-035 Opcode=111111 in RUN -> same cycle pc_en=0 we=0; next cycle halted=1; 10 more cycles of Opcode=000000 -> retired unchanged.
REQ-036 RETIRE_W=4, 20 ALU instructions -> retired saturates at 15.
REQ-037 Reset asserted asynchronously between edges during LI -> we drops to 0 before next edge; retired=0.
REQ-038 CTRL_UNIT_STEP_EN, step_mode=1, three 4-phase step_req handshakes -> exactly three step_ack pulses, retired=3, pc_en high only in those three cycles.

Source files
------------

// File: rtl/ctrl_unit_pkg.sv
// Shared definitions for the ctrl_unit controller: opcodes, class patterns, control word, FSM states.
// Optional single-step states exist only when CTRL_UNIT_STEP_EN is defined.
package ctrl_unit_pkg;

  localparam logic [5:0] OP_J    = 6'b100000;
  localparam logic [5:0] OP_JZ   = 6'b100001;
  localparam logic [5:0] OP_JNZ  = 6'b100010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // Low two opcode bits select the class when the top bit is clear.
  localparam logic [1:0] ALU_CLS = 2'b00;
  localparam logic [1:0] LI_CLS  = 2'b01;

  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we;
    logic       wez;
    logic [2:0] alu_op;
    logic       is_halt;
  } ctrl_word_t;

  localparam ctrl_word_t CW_IDLE = ctrl_word_t'{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};

`ifdef CTRL_UNIT_STEP_EN
  typedef enum logic [2:0] {
    ST_BOOT      = 3'd0,
    ST_RUN       = 3'd1,
    ST_HALT      = 3'd2,
    ST_STEP_WAIT = 3'd3,
    ST_STEP_EXEC = 3'd4,
    ST_STEP_DONE = 3'd5
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;
`endif

endpackage

// File: rtl/ctrl_unit_if.sv
// Datapath <-> controller signal bundle; step handshake signals present only with CTRL_UNIT_STEP_EN.
interface ctrl_unit_if #(
  parameter int RETIRE_W = 16
);
  logic [5:0]          Opcode;
  logic                zero;
  logic                s_inc;
  logic                s_inm;
  logic                we;
  logic                wez;
  logic [2:0]          ALUOp;
  logic                pc_en;
  logic                halted;
  logic [RETIRE_W-1:0] retired;
`ifdef CTRL_UNIT_STEP_EN
  logic                step_mode;
  logic                step_req;
  logic                step_ack;

  modport master (output Opcode, zero, step_mode, step_req,
                  input  s_inc, s_inm, we, wez, ALUOp, pc_en, halted, retired, step_ack);
  modport slave  (input  Opcode, zero, step_mode, step_req,
                  output s_inc, s_inm, we, wez, ALUOp, pc_en, halted, retired, step_ack);
`else
  modport master (output Opcode, zero,
                  input  s_inc, s_inm, we, wez, ALUOp, pc_en, halted, retired);
  modport slave  (input  Opcode, zero,
                  output s_inc, s_inm, we, wez, ALUOp, pc_en, halted, retired);
`endif
endinterface

// File: rtl/ctrl_unit_decode.sv
// Pure combinational opcode/zero -> control word decoder; HALT_OP takes priority over every class.
module ctrl_decode
  import ctrl_unit_pkg::*;
#(
  parameter logic [5:0] HALT_OP = OP_HALT
) (
  input  logic [5:0] opcode,
  input  logic       zero,
  output ctrl_word_t cw
);

  always_comb begin
    cw = CW_IDLE;
    if (opcode == HALT_OP) begin
      cw.is_halt = 1'b1;
    end else if (!opcode[5] && opcode[1:0] == ALU_CLS) begin
      cw.we     = 1'b1;
      cw.wez    = 1'b1;
      cw.alu_op = opcode[4:2];
    end else if (!opcode[5] && opcode[1:0] == LI_CLS) begin
      cw.we    = 1'b1;
      cw.s_inm = 1'b1;
    end else begin
      case (opcode)
        OP_J:    cw.s_inc = 1'b0;
        OP_JZ:   cw.s_inc = ~zero;
        OP_JNZ:  cw.s_inc = zero;
        default: cw.s_inc = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_unit.sv
// Controller FSM (BOOT/RUN/HALT) with zero-latency decode and saturating retired-instruction counter.
// Define CTRL_UNIT_STEP_EN to add the step_mode/step_req/step_ack single-step handshake.
module ctrl_unit
  import ctrl_unit_pkg::*;
#(
  parameter int         RETIRE_W = 16,
  parameter logic [5:0] HALT_OP  = OP_HALT
) (
  input  logic          clk,
  input  logic          reset,
  ctrl_unit_if.slave    bus
);

  state_e              state_q, state_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  ctrl_word_t          cw;
  logic                exec;
  logic                step_mode;
  logic                step_ack;
  logic                pc_en, we, wez, s_inc, s_inm, halted;
  logic [2:0]          alu_op;

  ctrl_decode #(.HALT_OP(HALT_OP)) u_decode (
    .opcode (bus.Opcode),
    .zero   (bus.zero),
    .cw     (cw)
  );

`ifdef CTRL_UNIT_STEP_EN
  assign step_mode = bus.step_mode;
  assign bus.step_ack = step_ack;
`else
  assign step_mode = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_BOOT;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef CTRL_UNIT_STEP_EN
      ST_BOOT:      state_d = step_mode ? ST_STEP_WAIT : ST_RUN;
      ST_RUN:       state_d = cw.is_halt ? ST_HALT : (step_mode ? ST_STEP_WAIT : ST_RUN);
      ST_STEP_WAIT: state_d = bus.step_req ? ST_STEP_EXEC : ST_STEP_WAIT;
      ST_STEP_EXEC: state_d = cw.is_halt ? ST_HALT : ST_STEP_DONE;
      ST_STEP_DONE: if (!bus.step_req) state_d = step_mode ? ST_STEP_WAIT : ST_RUN;
`else
      ST_BOOT:      state_d = ST_RUN;
      ST_RUN:       state_d = cw.is_halt ? ST_HALT : ST_RUN;
`endif
      default:      state_d = state_q;
    endcase
  end

  always_comb begin
    exec     = 1'b0;
    step_ack = 1'b0;
    halted   = 1'b0;
    pc_en    = 1'b0;
    we       = 1'b0;
    wez      = 1'b0;
    s_inc    = 1'b1;
    s_inm    = 1'b0;
    alu_op   = 3'b000;
    case (state_q)
      ST_RUN:  exec = 1'b1;
`ifdef CTRL_UNIT_STEP_EN
      ST_STEP_EXEC: begin
        exec     = 1'b1;
        step_ack = 1'b1;
      end
`endif
      ST_HALT: halted = 1'b1;
      default: exec = 1'b0;
    endcase
    // A halt opcode freezes the PC and suppresses writes in its own execute cycle.
    if (exec) begin
      pc_en  = ~cw.is_halt;
      we     = cw.we & ~cw.is_halt;
      wez    = cw.wez & ~cw.is_halt;
      s_inc  = cw.s_inc;
      s_inm  = cw.s_inm;
      alu_op = cw.alu_op;
    end
  end

  always_comb begin
    retired_d = retired_q;
    if (exec && !cw.is_halt && retired_q != {RETIRE_W{1'b1}})
      retired_d = retired_q + 1'b1;
  end

  assign bus.pc_en   = pc_en;
  assign bus.we      = we;
  assign bus.wez     = wez;
  assign bus.s_inc   = s_inc;
  assign bus.s_inm   = s_inm;
  assign bus.ALUOp   = alu_op;
  assign bus.halted  = halted;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed bench for ctrl_unit: decode vectors, boot/halt sequencing, async reset, counter saturation.
// The single-step section is compiled only when CTRL_UNIT_STEP_EN is defined.
module tb_ctrl_unit;

  logic clk;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_ret  = 0;

  ctrl_unit_if #(.RETIRE_W(16)) bus ();
  ctrl_unit_if #(.RETIRE_W(4))  bus4 ();

  ctrl_unit #(.RETIRE_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  ctrl_unit #(.RETIRE_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply an opcode just after a rising edge and stop at the following falling edge.
  task automatic step(input logic [5:0] op, input logic z);
    @(posedge clk);
    #1;
    bus.Opcode = op;
    bus.zero   = z;
    @(negedge clk);
  endtask

  task automatic chk_ctrl(input string tag, input logic pc, input logic w, input logic wz,
                          input logic inc, input logic inm, input logic [2:0] alu);
    chk({tag, ".pc_en"}, bus.pc_en, pc);
    chk({tag, ".we"},    bus.we,    w);
    chk({tag, ".wez"},   bus.wez,   wz);
    chk({tag, ".s_inc"}, bus.s_inc, inc);
    chk({tag, ".s_inm"}, bus.s_inm, inm);
    chk({tag, ".ALUOp"}, bus.ALUOp, alu);
  endtask

  task automatic exec_step(input string tag, input logic [5:0] op, input logic z,
                           input logic w, input logic wz, input logic inc, input logic inm,
                           input logic [2:0] alu);
    step(op, z);
    chk({tag, ".retired"}, bus.retired, exp_ret);
    chk_ctrl(tag, 1'b1, w, wz, inc, inm, alu);
    exp_ret++;
  endtask

`ifdef CTRL_UNIT_STEP_EN
  logic mon_en = 1'b0;
  int   n_pc   = 0;
  int   n_ack  = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.pc_en)    n_pc++;
      if (bus.step_ack) n_ack++;
    end
  end
`endif

  initial begin
    reset       = 1'b0;
    bus.Opcode  = 6'b000000;
    bus.zero    = 1'b0;
    bus4.Opcode = 6'b000000;
    bus4.zero   = 1'b0;
`ifdef CTRL_UNIT_STEP_EN
    bus.step_mode  = 1'b0;
    bus.step_req   = 1'b0;
    bus4.step_mode = 1'b0;
    bus4.step_req  = 1'b0;
`endif
    #1;
    chk_ctrl("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    chk("reset.halted",  bus.halted,  1'b0);
    chk("reset.retired", bus.retired, 0);

    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk_ctrl("boot", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);

    exec_step("alu0",   6'b000000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
    exec_step("li",     6'b010101, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000);
    exec_step("alu6",   6'b011000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b110);
    exec_step("j",      6'b100000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    exec_step("jz_z1",  6'b100001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    exec_step("jz_z0",  6'b100001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    exec_step("jnz_z1", 6'b100010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    exec_step("jnz_z0", 6'b100010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    exec_step("nop_a",  6'b100011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    exec_step("nop_b",  6'b000010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);

    step(6'b111111, 1'b0);
    chk_ctrl("halt_op", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    chk("halt_op.halted",  bus.halted,  1'b0);
    chk("halt_op.retired", bus.retired, 10);
    step(6'b000000, 1'b0);
    chk("halt.halted", bus.halted, 1'b1);
    chk_ctrl("halt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    for (int i = 0; i < 10; i++) step(6'b000000, 1'b0);
    chk("halt10.retired", bus.retired, 10);
    chk("halt10.halted",  bus.halted,  1'b1);
    chk("halt10.we",      bus.we,      1'b0);

    // Asynchronous reset in the middle of an LI cycle.
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_halt.halted", bus.halted, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    step(6'b010101, 1'b0);
    chk("li_pre.we",    bus.we,    1'b1);
    chk("li_pre.s_inm", bus.s_inm, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk_ctrl("li_rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    chk("li_rst.retired", bus.retired, 0);

    // Both counters run from the same release; the 4-bit one must stick at 15.
    @(posedge clk);
    #1;
    reset      = 1'b1;
    bus.Opcode = 6'b000000;
    @(negedge clk);
    for (int i = 1; i <= 21; i++) begin
      step(6'b000000, 1'b0);
      if (i == 15) chk("sat.r4_14", bus4.retired, 14);
      if (i == 16) chk("sat.r4_15", bus4.retired, 15);
    end
    chk("sat.r4_hold", bus4.retired, 15);
    chk("sat.r16",     bus.retired,  20);

`ifdef CTRL_UNIT_STEP_EN
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.step_mode = 1'b1;
    bus.step_req  = 1'b0;
    @(posedge clk);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;
    for (int h = 0; h < 3; h++) begin
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      bus.step_req = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 8 && !bus.step_ack; k++) @(negedge clk);
      chk("step.ack_seen", bus.step_ack, 1'b1);
      chk("step.pc_en",    bus.pc_en,    1'b1);
      @(posedge clk);
      #1;
      bus.step_req = 1'b0;
      repeat (3) @(negedge clk);
    end
    mon_en = 1'b0;
    chk("step.n_ack",   n_ack,       3);
    chk("step.n_pc",    n_pc,        3);
    chk("step.retired", bus.retired, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
